// File: rtl/ni_tx_packetizer_pkg.sv
// Shared definitions for the NI transmit packetizer: flit width, FSM encoding, head-flit layout.
// The CHK state exists only when NI_TX_CHECK_EN is defined.
package ni_tx_packetizer_pkg;

    localparam int FLIT_W = 4;

    typedef logic [FLIT_W-1:0] flit_t;

`ifdef NI_TX_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_CHK  = 2'd3
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } tx_state_t;
`endif

    // The head flit carries only the destination router address.
    typedef struct packed {
        logic [FLIT_W-1:0] dest;
    } head_flit_t;

endpackage

// File: rtl/ni_tx_packetizer_if.sv
// PE message handshake plus router local-port write/full handshake.
// slave = packetizer side, master = PE/router side.
interface ni_tx_packetizer_if
    import ni_tx_packetizer_pkg::*;
#(
    parameter int PAYLOAD_FLITS = 4
);
    logic                            msg_valid;
    logic                            msg_ready;
    logic [FLIT_W-1:0]               msg_dest;
    logic [FLIT_W*PAYLOAD_FLITS-1:0] msg_payload;
    logic [FLIT_W-1:0]               local_in;
    logic                            write_local;
    logic                            local_full;

    modport master (
        output msg_valid, msg_dest, msg_payload, local_full,
        input  msg_ready, local_in, write_local
    );

    modport slave (
        input  msg_valid, msg_dest, msg_payload, local_full,
        output msg_ready, local_in, write_local
    );

endinterface

// File: rtl/ni_tx_flit_mux.sv
// Selects the outgoing flit from FSM state, payload index and captured message.
// With NI_TX_CHECK_EN the XOR check flit is also generated here.
module ni_tx_flit_mux
    import ni_tx_packetizer_pkg::*;
#(
    parameter int PAYLOAD_FLITS = 4,
    parameter int IDX_W         = 2
) (
    input  tx_state_t                       state,
    input  logic [IDX_W-1:0]                idx,
    input  head_flit_t                      head,
    input  logic [FLIT_W*PAYLOAD_FLITS-1:0] payload,
    output flit_t                           flit
);

    flit_t body_flit;

    always_comb begin
        body_flit = '0;
        for (int i = 0; i < PAYLOAD_FLITS; i++) begin
            if (idx == IDX_W'(i)) begin
                body_flit = payload[i*FLIT_W +: FLIT_W];
            end
        end
    end

`ifdef NI_TX_CHECK_EN
    flit_t chk_flit;

    always_comb begin
        chk_flit = head.dest;
        for (int i = 0; i < PAYLOAD_FLITS; i++) begin
            chk_flit = chk_flit ^ payload[i*FLIT_W +: FLIT_W];
        end
    end
`endif

    // Driven purely from registered state so the router sees a stable flit under backpressure.
    always_comb begin
        flit = '0;
        case (state)
            ST_HEAD: flit = head.dest;
            ST_BODY: flit = body_flit;
`ifdef NI_TX_CHECK_EN
            ST_CHK:  flit = chk_flit;
`endif
            default: flit = '0;
        endcase
    end

endmodule

// File: rtl/ni_tx_packetizer.sv
// NI transmit stage: captures one PE message, serializes head/payload(/check) flits to the router.
// Optional feature macro: NI_TX_CHECK_EN (appends an XOR check flit to every packet).
module ni_tx_packetizer
    import ni_tx_packetizer_pkg::*;
#(
    parameter int PAYLOAD_FLITS = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    ni_tx_packetizer_if.slave tx,
    output logic              busy,
    output logic [CNT_W-1:0]  sent_count
);

    localparam int IDX_W = (PAYLOAD_FLITS > 1) ? $clog2(PAYLOAD_FLITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_FLITS - 1);

    tx_state_t                       state, state_nxt;
    logic [IDX_W-1:0]                idx, idx_nxt;
    head_flit_t                      head_q;
    logic [FLIT_W*PAYLOAD_FLITS-1:0] payload_q;
    logic                            capture;
    logic                            finish;
    logic                            accept;

    assign tx.msg_ready   = (state == ST_IDLE);
    assign busy           = ~tx.msg_ready;
    // Combinational from local_full: the router is expected to register its full flag.
    assign tx.write_local = (state != ST_IDLE) & ~tx.local_full;
    assign accept         = tx.write_local;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            sent_count <= '0;
            head_q     <= '0;
            payload_q  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (finish) begin
                sent_count <= sent_count + CNT_W'(1);
            end
            if (capture) begin
                head_q.dest <= tx.msg_dest;
                payload_q   <= tx.msg_payload;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx.msg_valid) begin
                    capture   = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (accept) begin
                    idx_nxt   = '0;
                    state_nxt = ST_BODY;
                end
            end
            ST_BODY: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
`ifdef NI_TX_CHECK_EN
                        state_nxt = ST_CHK;
`else
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
`endif
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
`ifdef NI_TX_CHECK_EN
            ST_CHK: begin
                if (accept) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    ni_tx_flit_mux #(
        .PAYLOAD_FLITS (PAYLOAD_FLITS),
        .IDX_W         (IDX_W)
    ) u_flit_mux (
        .state   (state),
        .idx     (idx),
        .head    (head_q),
        .payload (payload_q),
        .flit    (tx.local_in)
    );

endmodule

// File: tb/tb_ni_tx_packetizer.sv
// Directed self-checking bench for ni_tx_packetizer (PAYLOAD_FLITS=4, CNT_W=8).
// Expected flit sequences are hand-computed; NI_TX_CHECK_EN selects the packet length.
module tb_ni_tx_packetizer;
    import ni_tx_packetizer_pkg::*;

    localparam int P  = 4;
    localparam int CW = 8;
`ifdef NI_TX_CHECK_EN
    localparam int NF = P + 2;
`else
    localparam int NF = P + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic [CW-1:0] sent_count;

    ni_tx_packetizer_if #(.PAYLOAD_FLITS(P)) tx ();

    ni_tx_packetizer #(
        .PAYLOAD_FLITS (P),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx         (tx.slave),
        .busy       (busy),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_cnt;

    // dest 5, payload D3A1 -> 5,1,A,3,D, check 5^1^A^3^D = 0
    logic [3:0] seq_a [6] = '{4'h5, 4'h1, 4'hA, 4'h3, 4'hD, 4'h0};
    // dest 9, payload 4C72 -> 9,2,7,C,4, check 9^2^7^C^4 = 4
    logic [3:0] seq_b [6] = '{4'h9, 4'h2, 4'h7, 4'hC, 4'h4, 4'h4};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_msg(input logic [3:0] dest, input logic [15:0] payload);
        tx.msg_valid   = 1'b1;
        tx.msg_dest    = dest;
        tx.msg_payload = payload;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++; if (tx.msg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_msg_ready: got %b want 1", tx.msg_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (tx.write_local !== 1'b0) begin n_fail++; $display("FAIL reset_write_local: got %b want 0", tx.write_local); end
        n_checks++; if (tx.local_in !== 4'h0) begin n_fail++; $display("FAIL reset_local_in: got %h want 0", tx.local_in); end
        n_checks++; if (sent_count !== '0) begin n_fail++; $display("FAIL reset_sent_count: got %0d want 0", sent_count); end
        reset = 1'b0;
        exp_cnt = '0;
        step();
    endtask

    task automatic test_basic();
        int low_cycles;
        low_cycles = 0;
        drive_msg(4'h5, 16'hD3A1);
        #1;
        n_checks++; if (tx.msg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_pre: got %b want 1", tx.msg_ready); end
        step();
        tx.msg_valid = 1'b0;
        for (int k = 0; k < NF; k++) begin
            if (tx.msg_ready === 1'b0) low_cycles++;
            n_checks++; if (tx.write_local !== 1'b1) begin n_fail++; $display("FAIL basic_wr[%0d]: got %b want 1", k, tx.write_local); end
            n_checks++; if (tx.local_in !== seq_a[k]) begin n_fail++; $display("FAIL basic_flit[%0d]: got %h want %h", k, tx.local_in, seq_a[k]); end
            step();
        end
        exp_cnt++;
        n_checks++; if (low_cycles != NF) begin n_fail++; $display("FAIL basic_ready_low: got %0d want %0d", low_cycles, NF); end
        n_checks++; if (tx.msg_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_post: got %b want 1", tx.msg_ready); end
        n_checks++; if (tx.write_local !== 1'b0) begin n_fail++; $display("FAIL basic_wr_post: got %b want 0", tx.write_local); end
        n_checks++; if (sent_count !== exp_cnt) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", sent_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        drive_msg(4'h5, 16'hD3A1);
        step();
        tx.msg_valid = 1'b0;
        n_checks++; if (tx.local_in !== 4'h5 || tx.write_local !== 1'b1) begin n_fail++; $display("FAIL bp_head: got %h/%b want 5/1", tx.local_in, tx.write_local); end
        step();
        tx.local_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (tx.write_local !== 1'b0) begin n_fail++; $display("FAIL bp_stall_wr[%0d]: got %b want 0", c, tx.write_local); end
            n_checks++; if (tx.local_in !== 4'h1) begin n_fail++; $display("FAIL bp_stall_flit[%0d]: got %h want 1", c, tx.local_in); end
            step();
        end
        tx.local_full = 1'b0;
        #1;
        for (int k = 1; k < NF; k++) begin
            n_checks++; if (tx.write_local !== 1'b1) begin n_fail++; $display("FAIL bp_wr[%0d]: got %b want 1", k, tx.write_local); end
            n_checks++; if (tx.local_in !== seq_a[k]) begin n_fail++; $display("FAIL bp_flit[%0d]: got %h want %h", k, tx.local_in, seq_a[k]); end
            step();
        end
        exp_cnt++;
        n_checks++; if (sent_count !== exp_cnt) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", sent_count, exp_cnt); end
    endtask

    task automatic test_full_at_accept();
        drive_msg(4'h5, 16'hD3A1);
        tx.local_full = 1'b1;
        step();
        tx.msg_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (tx.write_local !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_stall[%0d]: wr %b busy %b want 0/1", c, tx.write_local, busy); end
            step();
        end
        tx.local_full = 1'b0;
        #1;
        for (int k = 0; k < NF; k++) begin
            n_checks++; if (tx.write_local !== 1'b1 || tx.local_in !== seq_a[k]) begin n_fail++; $display("FAIL full_flit[%0d]: got %h/%b want %h/1", k, tx.local_in, tx.write_local, seq_a[k]); end
            step();
        end
        exp_cnt++;
        n_checks++; if (sent_count !== exp_cnt) begin n_fail++; $display("FAIL full_count: got %0d want %0d", sent_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        drive_msg(4'h5, 16'hD3A1);
        step();
        // second message presented while busy; must not disturb the first
        drive_msg(4'h9, 16'h4C72);
        for (int k = 0; k < NF; k++) begin
            n_checks++; if (tx.write_local !== 1'b1 || tx.local_in !== seq_a[k]) begin n_fail++; $display("FAIL b2b_first[%0d]: got %h/%b want %h/1", k, tx.local_in, tx.write_local, seq_a[k]); end
            step();
        end
        n_checks++; if (tx.msg_ready !== 1'b1 || tx.write_local !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: ready %b wr %b want 1/0", tx.msg_ready, tx.write_local); end
        step();
        tx.msg_valid = 1'b0;
        for (int k = 0; k < NF; k++) begin
            n_checks++; if (tx.write_local !== 1'b1 || tx.local_in !== seq_b[k]) begin n_fail++; $display("FAIL b2b_second[%0d]: got %h/%b want %h/1", k, tx.local_in, tx.write_local, seq_b[k]); end
            step();
        end
        exp_cnt = exp_cnt + 2;
        n_checks++; if (sent_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", sent_count, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        drive_msg(4'h5, 16'hD3A1);
        step();
        tx.msg_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        n_checks++; if (tx.write_local !== 1'b0 || tx.local_in !== 4'h0) begin n_fail++; $display("FAIL rmid_out: got %h/%b want 0/0", tx.local_in, tx.write_local); end
        n_checks++; if (tx.msg_ready !== 1'b1 || sent_count !== '0) begin n_fail++; $display("FAIL rmid_state: ready %b count %0d want 1/0", tx.msg_ready, sent_count); end
        reset = 1'b0;
        exp_cnt = '0;
        step();
        drive_msg(4'h9, 16'h4C72);
        step();
        tx.msg_valid = 1'b0;
        for (int k = 0; k < NF; k++) begin
            n_checks++; if (tx.write_local !== 1'b1 || tx.local_in !== seq_b[k]) begin n_fail++; $display("FAIL rmid_flit[%0d]: got %h/%b want %h/1", k, tx.local_in, tx.write_local, seq_b[k]); end
            step();
        end
        exp_cnt++;
        n_checks++; if (sent_count !== exp_cnt) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", sent_count, exp_cnt); end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int n = 0; n < 255; n++) begin
            drive_msg(4'h3, 16'h1234);
            step();
            tx.msg_valid = 1'b0;
            repeat (NF) step();
        end
        n_checks++; if (sent_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", sent_count); end
        drive_msg(4'h3, 16'h1234);
        step();
        tx.msg_valid = 1'b0;
        repeat (NF) step();
        n_checks++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", sent_count); end
    endtask

    initial begin
        reset          = 1'b1;
        tx.msg_valid   = 1'b0;
        tx.msg_dest    = '0;
        tx.msg_payload = '0;
        tx.local_full  = 1'b0;
        exp_cnt        = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_full_at_accept();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
